// File: rtl/flash_arbiter_if.sv
// Signal bundle for one requester attached to the flash arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface flash_arbiter_if;
   logic       req;
   logic       gnt;
   logic       csb;
   logic       sclk;
   logic [3:0] io_oe;
   logic [3:0] io_do;
   logic [3:0] io_di;

   modport master (output req, csb, sclk, io_oe, io_do, input gnt, io_di);
   modport slave  (input req, csb, sclk, io_oe, io_do, output gnt, io_di);
endinterface

// File: rtl/flash_arbiter.sv
// Two-way round-robin arbiter for the QSPI flash pins, with a registered grant.
// Ownership changes only at chip-select boundaries, with a guard gap and optional hold-time preemption.
module flash_arbiter #(
   parameter int GUARD_CYCLES = 2,
   parameter int MAX_HOLD     = 0
) (
   input  logic           clk,
   input  logic           reset,
   flash_arbiter_if.slave r0,
   flash_arbiter_if.slave r1,
   output logic           flash_csb,
   output logic           flash_clk,
   output logic [3:0]     flash_io_oe,
   output logic [3:0]     flash_io_do,
   input  logic [3:0]     flash_io_di,
   output logic           busy,
   output logic           abort
);

   localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_SAT = '1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

   state_t        state;
   logic          last;
   logic          gnt0, gnt1;
   logic [GW-1:0] guard_cnt;
   logic [HW-1:0] hold_cnt;

   logic own_req, own_csb, other_req, hold_done, release_own, any_req, pick1;

   assign own_req   = (state == OWN1) ? r1.req : r0.req;
   assign own_csb   = (state == OWN1) ? r1.csb : r0.csb;
   assign other_req = (state == OWN1) ? r0.req : r1.req;
   assign hold_done = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD);
   // Preemption waits for the owner's csb to be high so no transfer is cut short.
   assign release_own = !own_req || (hold_done && other_req && own_csb);

   // On a tie the port that was not granted last wins.
   assign any_req = r0.req || r1.req;
   assign pick1   = r1.req && (!r0.req || !last);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         guard_cnt <= '0;
         hold_cnt  <= '0;
         abort     <= 1'b0;
      end else begin
         abort <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= pick1 ? OWN1 : OWN0;
                  gnt0     <= !pick1;
                  gnt1     <= pick1;
                  last     <= pick1;
                  hold_cnt <= '0;
               end
            end
            OWN0, OWN1: begin
               if (release_own) begin
                  state     <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
                  gnt0      <= 1'b0;
                  gnt1      <= 1'b0;
                  guard_cnt <= '0;
                  abort     <= !own_csb;
               end else if (other_req && hold_cnt != HOLD_SAT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GUARD: begin
               if (int'(guard_cnt) + 1 >= GUARD_CYCLES) state <= IDLE;
               else                                     guard_cnt <= guard_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign r0.gnt = gnt0;
   assign r1.gnt = gnt1;

   // NOTE: every output of this combinational mux gets a default first, so no latch is inferred.
   always_comb begin
      flash_csb   = 1'b1;
      flash_clk   = 1'b0;
      flash_io_oe = 4'b0;
      flash_io_do = 4'b0;
      if (gnt0) begin
         flash_csb   = r0.csb;
         flash_clk   = r0.sclk;
         flash_io_oe = r0.io_oe;
         flash_io_do = r0.io_do;
      end else if (gnt1) begin
         flash_csb   = r1.csb;
         flash_clk   = r1.sclk;
         flash_io_oe = r1.io_oe;
         flash_io_do = r1.io_do;
      end
   end

   assign r0.io_di = gnt0 ? flash_io_di : 4'b0;
   assign r1.io_di = gnt1 ? flash_io_di : 4'b0;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed scenarios followed by random traffic.
// The reference model tracks the owner, the guard countdown and the hold time as plain integers.
module tb_flash_arbiter;
   localparam int G = 2;
   localparam int H = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   flash_arbiter_if r0_if ();
   flash_arbiter_if r1_if ();

   logic       flash_csb, flash_clk, busy, abort;
   logic [3:0] flash_io_oe, flash_io_do, flash_io_di;

   flash_arbiter #(.GUARD_CYCLES(G), .MAX_HOLD(H)) dut (
      .clk         (clk),
      .reset       (reset),
      .r0          (r0_if),
      .r1          (r1_if),
      .flash_csb   (flash_csb),
      .flash_clk   (flash_clk),
      .flash_io_oe (flash_io_oe),
      .flash_io_do (flash_io_do),
      .flash_io_di (flash_io_di),
      .busy        (busy),
      .abort       (abort)
   );

   int passed = 0;
   int total  = 0;

   // Model: owner is -1 for none; guard_left counts remaining guard cycles.
   int m_owner, m_guard_left, m_hold;
   bit m_last, m_abort;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_owner = -1; m_guard_left = 0; m_hold = 0; m_last = 1'b1; m_abort = 1'b0;
   endtask

   task automatic model_step();
      bit req [2];
      bit csb [2];
      int o;
      req[0] = r0_if.req; req[1] = r1_if.req;
      csb[0] = r0_if.csb; csb[1] = r1_if.csb;
      m_abort = 1'b0;
      if (m_owner >= 0) begin
         o = 1 - m_owner;
         if (!req[m_owner] || (H != 0 && m_hold >= H && req[o] && csb[m_owner])) begin
            m_abort      = !csb[m_owner];
            m_owner      = -1;
            m_guard_left = G;
         end else if (req[o] && m_hold < H) begin
            m_hold++;
         end
      end else if (m_guard_left > 0) begin
         m_guard_left--;
      end else if (req[0] || req[1]) begin
         if (req[0] && req[1]) m_owner = m_last ? 0 : 1;
         else                  m_owner = req[0] ? 0 : 1;
         m_last = (m_owner == 1);
         m_hold = 0;
      end
   endtask

   task automatic check_outputs();
      logic       e_csb, e_clk;
      logic [3:0] e_oe, e_do;
      e_csb = 1'b1; e_clk = 1'b0; e_oe = 4'h0; e_do = 4'h0;
      if (m_owner == 0) begin
         e_csb = r0_if.csb; e_clk = r0_if.sclk; e_oe = r0_if.io_oe; e_do = r0_if.io_do;
      end else if (m_owner == 1) begin
         e_csb = r1_if.csb; e_clk = r1_if.sclk; e_oe = r1_if.io_oe; e_do = r1_if.io_do;
      end
      check("gnt0",  r0_if.gnt, 32'(m_owner == 0));
      check("gnt1",  r1_if.gnt, 32'(m_owner == 1));
      check("busy",  busy,  32'(m_owner >= 0 || m_guard_left > 0));
      check("abort", abort, 32'(m_abort));
      check("csb",   flash_csb, e_csb);
      check("sclk",  flash_clk, e_clk);
      check("oe",    flash_io_oe, e_oe);
      check("do",    flash_io_do, e_do);
      check("di0",   r0_if.io_di, (m_owner == 0) ? flash_io_di : 4'h0);
      check("di1",   r1_if.io_di, (m_owner == 1) ? flash_io_di : 4'h0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(input int p, input bit req, input bit csb, input bit sclk,
                        input logic [3:0] oe, input logic [3:0] dout);
      if (p == 0) begin
         r0_if.req = req; r0_if.csb = csb; r0_if.sclk = sclk; r0_if.io_oe = oe; r0_if.io_do = dout;
      end else begin
         r1_if.req = req; r1_if.csb = csb; r1_if.sclk = sclk; r1_if.io_oe = oe; r1_if.io_do = dout;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      check("rst_csb",  flash_csb, 1);
      check("rst_oe",   flash_io_oe, 0);
      check("rst_gnt",  {r0_if.gnt, r1_if.gnt}, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      flash_io_di = 4'h0;
      drive(0, 0, 1, 0, 4'h0, 4'h0);
      drive(1, 0, 1, 0, 4'h0, 4'h0);

      // 1: single request is granted after reset; pins follow port 0.
      drive(0, 1, 0, 1, 4'hf, 4'ha);
      drive(1, 0, 0, 1, 4'h5, 4'h5);
      apply_reset();
      tick();
      tick();
      check("t1_gnt0", r0_if.gnt, 1);
      check("t1_do",   flash_io_do, 4'ha);
      check("t1_oe",   flash_io_oe, 4'hf);
      flash_io_di = 4'h6;
      #1;
      check("t1_di0", r0_io_di_now(), 4'h6);
      check("t1_di1", r1_if.io_di, 4'h0);

      // 2: tie goes to port 0; release gives two guard cycles plus one idle cycle.
      drive(0, 1, 1, 0, 4'h0, 4'h0);
      drive(1, 1, 1, 0, 4'h3, 4'h3);
      apply_reset();
      tick();
      check("t2_first", r0_if.gnt, 1);
      r0_if.req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_gap_csb", flash_csb, 1);
         check("t2_gap_g1",  r1_if.gnt, 0);
      end
      tick();
      check("t2_g1", r1_if.gnt, 1);

      // 3: immediate re-requests alternate ownership.
      drive(0, 1, 1, 0, 4'h0, 4'h0);
      drive(1, 1, 1, 0, 4'h0, 4'h0);
      apply_reset();
      for (int round = 0; round < 4; round++) begin
         int n;
         n = 0;
         while (!(r0_if.gnt || r1_if.gnt) && n < 20) begin
            tick();
            n++;
         end
         check("t3_wait", 32'(n < 20), 1);
         check("t3_owner0", r0_if.gnt, 32'(round % 2 == 0));
         check("t3_overlap", 32'(r0_if.gnt && r1_if.gnt), 0);
         tick();
         if (r0_if.gnt) r0_if.req = 1'b0; else r1_if.req = 1'b0;
         tick();
         r0_if.req = 1'b1;
         r1_if.req = 1'b1;
      end

      // 4a: with csb high, preemption lands on exactly the cycle hold reaches MAX_HOLD.
      drive(0, 1, 1, 0, 4'h0, 4'h0);
      drive(1, 0, 1, 0, 4'h0, 4'h0);
      apply_reset();
      tick();
      r1_if.req = 1'b1;
      repeat (H) tick();
      check("t4_before", r0_if.gnt, 1);
      tick();
      check("t4_preempt", r0_if.gnt, 0);
      check("t4_noabort", abort, 0);

      // 4b: owner mid-transfer keeps grant past MAX_HOLD until csb rises.
      drive(0, 1, 0, 1, 4'h1, 4'h1);
      drive(1, 0, 1, 0, 4'h0, 4'h0);
      apply_reset();
      tick();
      r1_if.req = 1'b1;
      repeat (12) tick();
      check("t4_hold_csb0", r0_if.gnt, 1);
      r0_if.csb = 1'b1;
      tick();
      check("t4_csb1_rel", r0_if.gnt, 0);
      repeat (3) tick();
      check("t4_r1_turn", r1_if.gnt, 1);
      r1_if.req = 1'b0;
      repeat (4) tick();
      check("t4_r0_back", r0_if.gnt, 1);

      // 5: owner drops request mid-transfer.
      drive(0, 0, 1, 0, 4'h0, 4'h0);
      drive(1, 1, 1, 0, 4'h0, 4'h0);
      apply_reset();
      tick();
      check("t5_gnt1", r1_if.gnt, 1);
      r1_if.csb = 1'b0;
      tick();
      r1_if.req = 1'b0;
      tick();
      check("t5_abort", abort, 1);
      check("t5_csb",   flash_csb, 1);
      check("t5_busy",  busy, 1);
      tick();
      check("t5_abort_end", abort, 0);

      // 6: asynchronous reset during a port 1 burst idles the pins at once.
      drive(0, 0, 1, 0, 4'h0, 4'h0);
      drive(1, 1, 0, 1, 4'hf, 4'h3);
      apply_reset();
      tick();
      tick();
      check("t6_owned", flash_csb, 0);
      #2;
      reset = 1'b1;
      #1;
      check("t6_csb",   flash_csb, 1);
      check("t6_oe",    flash_io_oe, 0);
      check("t6_gnt1",  r1_if.gnt, 0);
      check("t6_abort", abort, 0);
      @(posedge clk);
      #1;
      check("t6_abort_hold", abort, 0);
      reset = 1'b0;
      model_reset();

      // Random traffic against the model.
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) r0_if.req = ~r0_if.req;
         if ($urandom_range(0, 7) == 0) r1_if.req = ~r1_if.req;
         if ($urandom_range(0, 2) == 0) r0_if.csb = ~r0_if.csb;
         if ($urandom_range(0, 2) == 0) r1_if.csb = ~r1_if.csb;
         r0_if.sclk  = 1'($urandom);
         r1_if.sclk  = 1'($urandom);
         r0_if.io_oe = 4'($urandom);
         r1_if.io_oe = 4'($urandom);
         r0_if.io_do = 4'($urandom);
         r1_if.io_do = 4'($urandom);
         flash_io_di = 4'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   function automatic logic [3:0] r0_io_di_now();
      return r0_if.io_di;
   endfunction

endmodule
